// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB requester for the timer subsystem.
// Turns a valid/ready command into one APB SETUP/ACCESS transfer and returns
// read data and error status on a single-cycle response strobe.
// One transfer is outstanding at a time.
// Optional build macro: APB_MASTER_TIMEOUT_EN. When defined, an ACCESS phase
// with PREADY low for TIMEOUT_CYCLES cycles is aborted with an error response.
module apb_master_ctrl #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              busy_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic              rsp_timeout_nxt;
    logic              timeout_hit;

    // Only command acceptance is combinational; everything else is registered.
    assign cmd_ready = (state == IDLE) && !PRESET;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_nxt;

    // Count stalled ACCESS cycles; held at zero outside ACCESS so every ACCESS starts fresh.
    always_comb begin
        to_cnt_nxt  = '0;
        timeout_hit = 1'b0;
        if (state == ACCESS && !PREADY) begin
            to_cnt_nxt  = to_cnt + 1'b1;
            timeout_hit = (to_cnt_nxt == CNT_LIMIT);
        end
    end

    // Stall counter register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output decode for the transfer sequencer.
    always_comb begin
        state_nxt       = state;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        pwrite_nxt      = PWRITE;
        paddr_nxt       = PADDR;
        pwdata_nxt      = PWDATA;
        busy_nxt        = busy;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt   = SETUP;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    pwdata_nxt  = cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                // PREADY wins over the timeout on the same edge.
                if (PREADY) begin
                    state_nxt       = IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    busy_nxt        = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = PSLVERR;
                    rsp_rdata_nxt   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    rsp_timeout_nxt = 1'b0;
                end else if (timeout_hit) begin
                    state_nxt       = IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    busy_nxt        = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_timeout_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and abandons any transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PWRITE      <= pwrite_nxt;
            PADDR       <= paddr_nxt;
            PWDATA      <= pwdata_nxt;
            busy        <= busy_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard bench for apb_master_ctrl with a register
// slave model (addresses 0..2 valid, address 3 answers with PSLVERR).
`timescale 1ns/1ps
module tb_apb_master_ctrl;

    localparam int TMO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [1:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    apb_master_ctrl #(.ADDR_W(2), .DATA_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } fld_t;

    exp_t exp_q[$];
    fld_t fld_q[$];
    int   wait_q[$];

    logic [7:0] ref_regs [4];
    logic [7:0] slv_regs [4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit rst_q = 1'b0;
    int last_acc = -10;
    int last_rsp_cyc = -10;
    logic [7:0] last_rd = 8'h00;
    logic last_err = 1'b0;
    logic last_to = 1'b0;

    fld_t s_f;
    int   s_rem = 0;
    int   s_phase = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge PCLK) begin
        cyc   <= cyc + 1;
        rst_q <= PRESET;
        armed <= 1'b1;
    end

    // Monitor: reset values, interface invariants, and scoreboard pops on rsp_valid.
    always @(negedge PCLK) begin
        if (armed) begin
            if (rst_q) begin
                chk("rst_psel", PSEL, 0);
                chk("rst_penable", PENABLE, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_timeout", rsp_timeout, 0);
                chk("rst_pwrite", PWRITE, 0);
                chk("rst_paddr", PADDR, 0);
                chk("rst_pwdata", PWDATA, 0);
                chk("rst_cmd_ready", cmd_ready, !PRESET);
                last_rd  = 8'h00;
                last_err = 1'b0;
                last_to  = 1'b0;
            end else begin
                chk("cmd_ready_idle", cmd_ready, !busy && !PRESET);
                chk("busy_vs_psel", busy, PSEL);
                chk("penable_needs_psel", PENABLE && !PSEL, 0);
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp_valid", rsp_valid, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_timeout", rsp_timeout, e.to);
                        chk("rsp_latency", cyc - e.acc, e.lat);
                    end
                    last_rd      = rsp_rdata;
                    last_err     = rsp_err;
                    last_to      = rsp_timeout;
                    last_rsp_cyc = cyc;
                end else begin
                    chk("hold_rsp_rdata", rsp_rdata, last_rd);
                    chk("hold_rsp_err", rsp_err, last_err);
                    chk("hold_rsp_timeout", rsp_timeout, last_to);
                end
            end
        end
    end

    // Slave model: random junk outside ACCESS, programmed wait states, error at address 3.
    initial begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && !PENABLE) begin
                if (fld_q.size() == 0 || wait_q.size() == 0) begin
                    chk("unexpected_setup", 1, 0);
                    s_phase = 0;
                end else begin
                    s_f   = fld_q.pop_front();
                    s_rem = wait_q.pop_front();
                    chk("setup_delay", cyc, last_acc + 1);
                    chk("setup_paddr", PADDR, s_f.addr);
                    chk("setup_pwrite", PWRITE, s_f.wr);
                    chk("setup_pwdata", PWDATA, s_f.data);
                    s_phase = 1;
                end
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = 8'($urandom);
            end else if (PSEL && PENABLE) begin
                chk("access_after_setup", s_phase != 0, 1);
                chk("access_paddr", PADDR, s_f.addr);
                chk("access_pwrite", PWRITE, s_f.wr);
                chk("access_pwdata", PWDATA, s_f.data);
                s_phase = 2;
                if (s_rem == 0) begin
                    PREADY  = 1'b1;
                    PSLVERR = (PADDR == 2'd3);
                    if (PWRITE) begin
                        PRDATA = 8'($urandom);
                        if (PADDR != 2'd3) slv_regs[PADDR] = PWDATA;
                    end else begin
                        PRDATA = (PADDR == 2'd3) ? 8'($urandom) : slv_regs[PADDR];
                    end
                end else begin
                    s_rem--;
                    PREADY  = 1'b0;
                    PSLVERR = 1'($urandom);
                    PRDATA  = 8'($urandom);
                end
            end else begin
                s_phase = 0;
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = 8'($urandom);
            end
        end
    end

    // Issue one command, push its expected response at acceptance, optionally leave cmd_valid high.
    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         input int w, input bit hold);
        int   n;
        bit   b2b;
        exp_t e;
        fld_t f;
        b2b       = (cmd_valid === 1'b1);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge PCLK);
            #1;
            if (cmd_ready === 1'b1) break;
            n++;
            if (n > 400) begin
                chk("accept_timeout", n, 0);
                cmd_valid = 1'b0;
                return;
            end
        end
        e.to    = TO_EN && (w >= TMO);
        e.err   = e.to || (a == 2'd3);
        e.rdata = (!wr && !e.err) ? ref_regs[a] : 8'h00;
        e.lat   = e.to ? (2 + TMO) : (3 + w);
        e.acc   = cyc;
        if (wr && !e.err) ref_regs[a] = d;
        exp_q.push_back(e);
        f.wr   = wr;
        f.addr = a;
        f.data = d;
        fld_q.push_back(f);
        wait_q.push_back(w);
        if (b2b) chk("b2b_one_idle_cycle", cyc, last_rsp_cyc);
        last_acc = cyc;
        @(posedge PCLK);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_pending_rsp", exp_q.size(), 0);
        idle_cycles(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       wr;
        logic [1:0] a;
        logic [7:0] d;
        int         w;
        bit         hold;

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            if (i == 2) d = 8'h03;
            ref_regs[i] = d;
            slv_regs[i] = d;
        end
        idle_cycles(3);
        PRESET = 1'b0;
        idle_cycles(2);

        // Directed: write no-wait, read with waits, error then clean read, held cmd_valid pair.
        issue(1'b1, 2'd0, 8'hA5, 0, 1'b0);
        idle_cycles(2);
        issue(1'b0, 2'd2, 8'h00, 3, 1'b0);
        idle_cycles(1);
        issue(1'b1, 2'd3, 8'h77, 0, 1'b0);
        issue(1'b0, 2'd1, 8'h00, 1, 1'b0);
        idle_cycles(1);
        issue(1'b1, 2'd1, 8'h5C, 0, 1'b1);
        issue(1'b0, 2'd1, 8'hEE, 0, 1'b0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            wr   = 1'($urandom);
            a    = 2'($urandom);
            d    = 8'($urandom);
            w    = $urandom_range(0, 4);
            hold = (i != 79) && ($urandom_range(0, 2) == 0);
            issue(wr, a, d, w, hold);
            if (!hold) idle_cycles($urandom_range(0, 2));
        end
        drain();

        // Reset mid-ACCESS: transfer abandoned, no response may follow.
        issue(1'b0, 2'd1, 8'h00, 30, 1'b0);
        idle_cycles(3);
        chk("pre_reset_in_access", PENABLE, 1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        exp_q.delete();
        idle_cycles(30);
        issue(1'b0, 2'd2, 8'h00, 1, 1'b0);
        drain();

        // Long stalls around the timeout limit.
        issue(1'b1, 2'd0, 8'h3C, TMO - 1, 1'b0);
        drain();
        issue(1'b1, 2'd2, 8'h96, TMO, 1'b0);
        drain();
        issue(1'b0, 2'd1, 8'h00, 120, 1'b0);
        drain();
        issue(1'b0, 2'd0, 8'h00, 0, 1'b0);
        issue(1'b0, 2'd2, 8'h00, 0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
